ro_freq_meter: RTL

Parametrised frequency meter for the ring-oscillator array, replacing the fixed 16:1 output mux.
- Selects one of `NUM_CH` pre-divided oscillator taps and enables the oscillators only while a measurement runs.
- Counts rising edges of the selected tap over a programmable window of system-clock cycles and holds the result for readout.
- Fully synchronous to the wishbone clock.
- Sits between the oscillator macros and the user I/O / wishbone register file.

---
 rtl/ro_meas_pkg.sv | 28 ++
 rtl/ro_edge_sync.sv | 57 +++++
 rtl/ro_freq_meter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ro_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ro_meas_pkg
// Description : Shared types and default constants for the ring-oscillator
//               frequency meter (FSM state encoding, parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package ro_meas_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } ro_meas_state_e;

  // Default parameter values
  localparam int NUM_CH_DEF = 80;   // 16 oscillators x 5 taps
  localparam int WIN_W_DEF  = 16;
  localparam int CNT_W_DEF  = 24;
  localparam int SETTLE_DEF = 8;

  // Smallest settle time that still flushes the tap mux + synchroniser
  localparam int SETTLE_MIN = 3;

endpackage : ro_meas_pkg
`default_nettype wire

// File: rtl/ro_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : ro_edge_sync
// Description : Registered tap multiplexer, 2-flop synchroniser and an extra
//               flop for rising-edge detection of the selected tap.
// Ports       : clk_i  - system clock
//               rst_i  - asynchronous active-high reset
//               ro_i   - asynchronous oscillator taps
//               sel_i  - tap select (already qualified by the caller)
//               rise_o - one-cycle pulse per synchronised rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_sync #(
  parameter int NUM_CH = 80,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] ro_i,
  input  logic [CH_W-1:0]   sel_i,
  output logic              rise_o
);

  logic tap_d;
  logic tap_q;
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // Explicit compare loop keeps out-of-range selects at a defined 0
  always_comb begin
    tap_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_i == i[CH_W-1:0]) begin
        tap_d = ro_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      tap_q   <= tap_d;
      sync1_q <= tap_q;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~sync3_q;

endmodule : ro_edge_sync
`default_nettype wire

// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : ro_freq_meter
// Description : Ring-oscillator frequency meter. Selects one pre-divided tap,
//               enables the oscillators, waits a settle time, then counts
//               synchronised rising edges over a programmable window.
// Ports       : wb_clk_i/wb_rst_i - clock, async active-high reset
//               ro_in             - oscillator taps (asynchronous)
//               ch_sel_i/window_i - measurement setup, sampled on start
//               start_i/abort_i   - control
//               ro_en_o, ch_sel_o, busy_o, done_o, err_o, ovf_o, count_o
// Revision    : 1.0 - initial release
// ============================================================================
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int WIN_W  = WIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [CH_W-1:0]   ch_sel_i,
  input  logic [WIN_W-1:0]  window_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              ro_en_o,
  output logic [CH_W-1:0]   ch_sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int C_SETTLE = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int C_SET_W  = $clog2(C_SETTLE);
  localparam logic [C_SET_W-1:0] C_SETTLE_LOAD = C_SET_W'(C_SETTLE - 1);
  localparam logic [CH_W:0]      C_NUM_CH      = NUM_CH[CH_W:0];

  ro_meas_state_e       state_q,  state_d;
  logic [C_SET_W-1:0]   settle_q, settle_d;
  logic [WIN_W-1:0]     win_q,    win_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic [CH_W-1:0]      ch_sel_q, ch_sel_d;
  logic                 ovf_q,    ovf_d;
  logic                 done_q,   done_d;
  logic                 err_q,    err_d;
  logic                 start_ok;
  logic                 rise;

  // The synchroniser follows the next-state channel so the tap mux switches
  // on the accepting edge; the settle time then covers the whole pipeline.
  ro_edge_sync #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_edge_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .ro_i   (ro_in),
    .sel_i  (ch_sel_d),
    .rise_o (rise)
  );

  assign start_ok = start_i && (window_i != '0) && ({1'b0, ch_sel_i} < C_NUM_CH);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      ch_sel_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      ch_sel_q <= ch_sel_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    ch_sel_d = ch_sel_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          ch_sel_d = ch_sel_i;
          // Window counter holds remaining cycles minus one
          win_d    = window_i - WIN_W'(1);
          settle_d = C_SETTLE_LOAD;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          done_d   = 1'b0;
          state_d  = ST_SETTLE;
        end else if (start_i) begin
          err_d = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort_i) begin
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (settle_q == '0) begin
          state_d = ST_COUNT;
        end else begin
          settle_d = settle_q - C_SET_W'(1);
        end
      end

      ST_COUNT: begin
        if (abort_i) begin
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (rise) begin
            if (cnt_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (win_q == '0) begin
            // Final cycle: publish including this cycle's edge
            count_d = cnt_d;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            win_d = win_q - WIN_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o   = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
  assign ro_en_o  = busy_o;
  assign ch_sel_o = ch_sel_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign ovf_o    = ovf_q;
  assign count_o  = count_q;

endmodule : ro_freq_meter
`default_nettype wire
